pc_next_unit: RTL and testbench

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

---
 rtl/pc_next_unit_if.sv | 33 +++
 rtl/pc_next_unit.sv | 123 ++++++++++++
 tb/tb_pc_next_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pc_next_unit_if.sv
// Control inputs and PC/stack status outputs of the next-PC unit.
// The master modport is the decode side; the slave modport is pc_next_unit.
interface pc_next_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 2
);
    logic                      stall;
    logic [1:0]                sel;
    logic                      branch_taken;
    logic [WIDTH-1:0]          immediate;
    logic [WIDTH-5-SHIFT:0]    jump_index;
    logic [WIDTH-1:0]          reg_target;
    logic                      call;
    logic                      ret;

    logic [WIDTH-1:0]          pcOut;
    logic [WIDTH-1:0]          pcPlus4;
    logic [WIDTH-1:0]          branchTarget;
    logic                      ras_empty;
    logic                      ras_full;
    logic                      ras_underflow;
    logic                      misalign;

    modport master (
        output stall, sel, branch_taken, immediate, jump_index, reg_target, call, ret,
        input  pcOut, pcPlus4, branchTarget, ras_empty, ras_full, ras_underflow, misalign
    );

    modport slave (
        input  stall, sel, branch_taken, immediate, jump_index, reg_target, call, ret,
        output pcOut, pcPlus4, branchTarget, ras_empty, ras_full, ras_underflow, misalign
    );
endinterface

// File: rtl/pc_next_unit.sv
// Next-PC select with a circular return-address stack and sticky underflow/misalign flags.
// Latency: one cycle to pcOut; backpressure: stall freezes all state, pcPlus4/branchTarget stay live.
module pc_next_unit #(
    parameter int               WIDTH     = 32,
    parameter int               SHIFT     = 2,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            reset,
    pc_next_unit_if.slave   bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] INSN_BYTES = WIDTH'(1) << SHIFT;
    localparam logic [WIDTH-1:0] ALIGN_MASK = INSN_BYTES - WIDTH'(1);
    localparam logic [CW-1:0]    DEPTH_C    = CW'(RAS_DEPTH);

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_REG    = 2'b11;

    logic [WIDTH-1:0]       pc_q;
    logic [WIDTH-1:0]       ras_mem [RAS_DEPTH];
    logic [PW-1:0]          wp_q;
    logic [CW-1:0]          cnt_q;
    logic                   empty_q;
    logic                   full_q;
    logic                   underflow_q;
    logic                   misalign_q;

    logic [WIDTH-1:0]       pc_plus;
    logic [WIDTH-1:0]       br_tgt;
    logic [WIDTH-SHIFT-1:0] jfield;
    logic [WIDTH-1:0]       jump_tgt;
    logic [PW-1:0]          top_idx;
    logic [WIDTH-1:0]       ras_top;
    logic [WIDTH-1:0]       next_raw;
    logic                   pop;
    logic [PW-1:0]          wp_nxt;
    logic [CW-1:0]          cnt_nxt;
    logic [PW-1:0]          wr_idx;

    assign pc_plus  = pc_q + INSN_BYTES;
    assign br_tgt   = pc_q + (bus.immediate << SHIFT);
    assign jfield   = {pc_q[WIDTH-1:WIDTH-4], bus.jump_index};
    assign jump_tgt = WIDTH'(jfield) << SHIFT;
    assign top_idx  = wp_q - PW'(1);
    assign ras_top  = ras_mem[top_idx];
    assign pop      = bus.ret && !empty_q;
    // A combined call+ret rewrites the slot being popped instead of pushing a new one.
    assign wr_idx   = pop ? top_idx : wp_q;

    always_comb begin
        next_raw = pc_plus;
        if (bus.ret) begin
            next_raw = empty_q ? bus.reg_target : ras_top;
        end else begin
            case (bus.sel)
                SEL_SEQ:    next_raw = pc_plus;
                SEL_BRANCH: next_raw = bus.branch_taken ? br_tgt : pc_plus;
                SEL_JUMP:   next_raw = jump_tgt;
                SEL_REG:    next_raw = bus.reg_target;
                default:    next_raw = pc_plus;
            endcase
        end
    end

    always_comb begin
        wp_nxt  = wp_q;
        cnt_nxt = cnt_q;
        if (bus.call && pop) begin
            wp_nxt  = wp_q;
            cnt_nxt = cnt_q;
        end else if (bus.call) begin
            // On a full stack the write pointer already sits on the oldest entry.
            wp_nxt  = wp_q + PW'(1);
            cnt_nxt = full_q ? cnt_q : cnt_q + CW'(1);
        end else if (pop) begin
            wp_nxt  = top_idx;
            cnt_nxt = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            wp_q        <= '0;
            cnt_q       <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            underflow_q <= 1'b0;
            misalign_q  <= 1'b0;
        end else if (!bus.stall) begin
            pc_q    <= next_raw & ~ALIGN_MASK;
            wp_q    <= wp_nxt;
            cnt_q   <= cnt_nxt;
            empty_q <= (cnt_nxt == '0);
            full_q  <= (cnt_nxt == DEPTH_C);
            if (bus.ret && empty_q) begin
                underflow_q <= 1'b1;
            end
            if ((next_raw & ALIGN_MASK) != '0) begin
                misalign_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !bus.stall && bus.call) begin
            ras_mem[wr_idx] <= pc_plus;
        end
    end

    assign bus.pcOut         = pc_q;
    assign bus.pcPlus4       = pc_plus;
    assign bus.branchTarget  = br_tgt;
    assign bus.ras_empty     = empty_q;
    assign bus.ras_full      = full_q;
    assign bus.ras_underflow = underflow_q;
    assign bus.misalign      = misalign_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed-vector bench for pc_next_unit: sequential/branch/jump/register selection,
// return-address stack wrap, combined call+ret, stall hold, sticky flags and reset priority.
module tb_pc_next_unit;
    localparam int WIDTH = 32;
    localparam int SHIFT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_next_unit_if #(.WIDTH(WIDTH), .SHIFT(SHIFT)) bus ();

    pc_next_unit #(
        .WIDTH(WIDTH), .SHIFT(SHIFT), .RAS_DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic c, input logic r, input logic [31:0] rt);
        bus.sel        = s;
        bus.call       = c;
        bus.ret        = r;
        bus.reg_target = rt;
    endtask

    task automatic load_pc(input logic [31:0] addr);
        drive(2'b11, 1'b0, 1'b0, addr);
        tick();
    endtask

    logic [31:0] ret_exp [5] = '{32'h14, 32'h10, 32'hC, 32'h8, 32'h300};

    initial begin
        reset            = 1'b1;
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.immediate    = '0;
        bus.jump_index   = '0;
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        expect_eq("rst_pc",        bus.pcOut, 32'h0);
        expect_eq("rst_plus4",     bus.pcPlus4, 32'h4);
        expect_eq("rst_empty",     32'(bus.ras_empty), 32'd1);
        expect_eq("rst_full",      32'(bus.ras_full), 32'd0);
        expect_eq("rst_underflow", 32'(bus.ras_underflow), 32'd0);
        expect_eq("rst_misalign",  32'(bus.misalign), 32'd0);
        reset = 1'b0;

        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_eq($sformatf("seq_%0d", i), bus.pcOut, 32'(i * 4));
        end
        bus.immediate = 32'h3;
        #1;
        expect_eq("comb_branch_target", bus.branchTarget, 32'h18);

        // Branch taken and not taken from 0x100 with a backward offset of two words.
        load_pc(32'h100);
        expect_eq("load_100", bus.pcOut, 32'h100);
        bus.immediate = 32'hFFFF_FFFE;
        bus.branch_taken = 1'b1;
        drive(2'b01, 1'b0, 1'b0, 32'h0);
        tick();
        expect_eq("branch_taken", bus.pcOut, 32'hF8);
        load_pc(32'h100);
        bus.branch_taken = 1'b0;
        drive(2'b01, 1'b0, 1'b0, 32'h0);
        tick();
        expect_eq("branch_not_taken", bus.pcOut, 32'h104);

        load_pc(32'hA000_0010);
        bus.jump_index = 26'h123;
        drive(2'b10, 1'b0, 1'b0, 32'h0);
        tick();
        expect_eq("jump", bus.pcOut, 32'hA000_048C);

        bus.stall = 1'b1;
        bus.immediate = 32'h4;
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        expect_eq("stall_hold_pc", bus.pcOut, 32'hA000_048C);
        expect_eq("stall_branch_target", bus.branchTarget, 32'hA000_049C);
        expect_eq("stall_plus4", bus.pcPlus4, 32'hA000_0490);
        bus.stall = 1'b0;

        load_pc(32'hFFFF_FFFC);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        expect_eq("wrap", bus.pcOut, 32'h0);
        expect_eq("no_misalign_yet", 32'(bus.misalign), 32'd0);

        // Five calls from 0x0 overflow the 4-entry stack, dropping the 0x4 return address.
        load_pc(32'h0);
        for (int i = 1; i <= 5; i++) begin
            drive(2'b00, 1'b1, 1'b0, 32'h0);
            tick();
            expect_eq($sformatf("call_%0d_pc", i), bus.pcOut, 32'(i * 4));
            expect_eq($sformatf("call_%0d_full", i), 32'(bus.ras_full), (i >= 4) ? 32'd1 : 32'd0);
        end
        expect_eq("calls_empty", 32'(bus.ras_empty), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, 1'b0, 1'b1, 32'h300);
            tick();
            expect_eq($sformatf("ret_%0d_pc", i + 1), bus.pcOut, ret_exp[i]);
            expect_eq($sformatf("ret_%0d_underflow", i + 1), 32'(bus.ras_underflow),
                      (i == 4) ? 32'd1 : 32'd0);
        end
        expect_eq("rets_empty", 32'(bus.ras_empty), 32'd1);
        bus.stall = 1'b1;
        drive(2'b00, 1'b0, 1'b1, 32'h400);
        tick();
        expect_eq("stalled_ret_pc", bus.pcOut, 32'h300);
        expect_eq("stalled_ret_empty", 32'(bus.ras_empty), 32'd1);
        bus.stall = 1'b0;

        drive(2'b11, 1'b1, 1'b0, 32'h500);
        tick();
        expect_eq("call_reg_pc", bus.pcOut, 32'h500);
        bus.stall = 1'b1;
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        tick();
        expect_eq("stall_ret_nonempty_pc", bus.pcOut, 32'h500);
        expect_eq("stall_ret_nonempty_empty", 32'(bus.ras_empty), 32'd0);
        bus.stall = 1'b0;
        tick();
        expect_eq("ret_after_stall", bus.pcOut, 32'h304);
        expect_eq("ret_after_stall_empty", 32'(bus.ras_empty), 32'd1);

        // Combined call+ret on a one-entry stack swaps the top in place.
        drive(2'b00, 1'b1, 1'b0, 32'h0);
        tick();
        drive(2'b00, 1'b1, 1'b1, 32'h0);
        tick();
        expect_eq("callret_pc", bus.pcOut, 32'h308);
        expect_eq("callret_empty", 32'(bus.ras_empty), 32'd0);
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        tick();
        expect_eq("callret_pop", bus.pcOut, 32'h30C);
        expect_eq("callret_pop_empty", 32'(bus.ras_empty), 32'd1);

        drive(2'b00, 1'b1, 1'b1, 32'h600);
        tick();
        expect_eq("callret_empty_pc", bus.pcOut, 32'h600);
        expect_eq("callret_empty_cnt1", 32'(bus.ras_empty), 32'd0);
        drive(2'b00, 1'b0, 1'b1, 32'h0);
        tick();
        expect_eq("callret_empty_pop", bus.pcOut, 32'h310);

        load_pc(32'h10);
        drive(2'b11, 1'b0, 1'b0, 32'h203);
        tick();
        expect_eq("misalign_pc", bus.pcOut, 32'h200);
        expect_eq("misalign_set", 32'(bus.misalign), 32'd1);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        expect_eq("misalign_sticky", 32'(bus.misalign), 32'd1);
        expect_eq("underflow_sticky", 32'(bus.ras_underflow), 32'd1);

        drive(2'b00, 1'b1, 1'b0, 32'h0);
        tick();
        reset = 1'b1;
        bus.stall = 1'b1;
        drive(2'b11, 1'b1, 1'b1, 32'h700);
        tick();
        expect_eq("reset_prio_pc", bus.pcOut, 32'h0);
        expect_eq("reset_prio_empty", 32'(bus.ras_empty), 32'd1);
        expect_eq("reset_prio_misalign", 32'(bus.misalign), 32'd0);
        expect_eq("reset_prio_underflow", 32'(bus.ras_underflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
